// File: rtl/adc_pkg.sv
// adc_pkg: shared ADC scan types, widths and channel/config helpers
package adc_pkg;
  localparam int CFG_W = 6;
  localparam int DATA_W = 12;
  typedef enum logic [1:0] {IDLE, CONV, SHIFT, GAP} state_t;
  function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] c, input logic u);
    return {1'b1, c[0], c[2], c[1], u, 1'b0};
  endfunction
  function automatic logic [2:0] first_chan(input logic [7:0] m);
    first_chan = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) first_chan = 3'(i);
  endfunction
  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] c);
    next_chan = c;
    for (int i = 7; i >= 1; i--) if (m[c + 3'(i)]) next_chan = c + 3'(i);
  endfunction
endpackage

// File: rtl/adc_serial_if.sv
// adc_serial_if: one converter frame (CONV, 12-bit SHIFT, 1-cycle GAP) started by frame_go; ports clk, rst_n, frame_go, cfg in, adc_sdo in, adc_convst/adc_sclk/adc_sdi out, frame_done (GAP cycle) and data out
module adc_serial_if import adc_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_go,
  input  logic [CFG_W-1:0]  cfg,
  input  logic              adc_sdo,
  output logic              adc_convst,
  output logic              adc_sclk,
  output logic              adc_sdi,
  output logic              frame_done,
  output logic [DATA_W-1:0] data
);
  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] HALF = 16'(CLK_DIV);
  localparam logic [15:0] BIT_LAST = 16'(2 * CLK_DIV - 1);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    bit_d = bit_q;
    cfg_d = cfg_q;
    sh_d = (state_q == SHIFT && cnt_q == HALF) ? {sh_q[DATA_W-2:0], adc_sdo} : sh_q;
    case (state_q)
      IDLE, GAP: begin
        state_d = frame_go ? CONV : IDLE;
        cnt_d = '0;
        cfg_d = frame_go ? cfg : cfg_q;
      end
      CONV: if (cnt_q == CONV_LAST) begin
        state_d = SHIFT;
        cnt_d = '0;
        bit_d = '0;
      end
      default: if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        bit_d = bit_q + 4'd1;
        state_d = (bit_q == 4'(DATA_W - 1)) ? GAP : SHIFT;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      cfg_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      cfg_q <= cfg_d;
      sh_q <= sh_d;
    end
  end
  assign adc_convst = state_q == CONV;
  assign adc_sclk = state_q == SHIFT && cnt_q >= HALF;
  assign adc_sdi = state_q == SHIFT && bit_q < 4'(CFG_W) && cfg_q[3'(CFG_W - 1) - bit_q[2:0]];
  assign frame_done = state_q == GAP;
  assign data = sh_q;
endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: masked channel scan over adc_serial_if (clk, rst_n, start, chan_mask, uni, cont when ADC_CONT_EN, adc_convst/adc_sclk/adc_sdi/adc_sdo, busy, result_valid/result_chan/result_data)
module adc_scan_ctrl import adc_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        chan_mask,
  input  logic              uni,
`ifdef ADC_CONT_EN
  input  logic              cont,
`endif
  input  logic              adc_sdo,
  output logic              adc_convst,
  output logic              adc_sclk,
  output logic              adc_sdi,
  output logic              busy,
  output logic              result_valid,
  output logic [2:0]        result_chan,
  output logic [DATA_W-1:0] result_data
);
  logic busy_q, busy_d, uni_q, uni_d, first_q, first_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] chan_q, chan_d, prev_q, prev_d, rc_q, rc_d, nxt;
  logic [DATA_W-1:0] rd_q, rd_d, data;
  logic [CFG_W-1:0] cfg;
  logic cont_en, accept, last, more, frame_go, frame_done;
`ifdef ADC_CONT_EN
  assign cont_en = cont;
`else
  assign cont_en = 1'b0;
`endif
  adc_serial_if #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES)) u_if (
    .clk(clk), .rst_n(rst_n), .frame_go(frame_go), .cfg(cfg), .adc_sdo(adc_sdo),
    .adc_convst(adc_convst), .adc_sclk(adc_sclk), .adc_sdi(adc_sdi),
    .frame_done(frame_done), .data(data)
  );
  assign accept = start && !busy_q && |chan_mask;
  assign last = !first_q && chan_q == first_chan(mask_q);
  assign more = frame_done && (!last || cont_en);
  assign frame_go = accept || more;
  assign nxt = accept ? first_chan(chan_mask) : next_chan(mask_q, chan_q);
  assign cfg = cfg_word(nxt, accept ? uni : uni_q);
  assign result_valid = frame_done && !first_q;
  assign result_chan = result_valid ? prev_q : rc_q;
  assign result_data = result_valid ? data : rd_q;
  assign busy = busy_q;
  always_comb begin
    busy_d = accept || (busy_q && !(frame_done && !more));
    mask_d = accept ? chan_mask : mask_q;
    uni_d = accept ? uni : uni_q;
    first_d = accept || (first_q && !more);
    chan_d = frame_go ? nxt : chan_q;
    prev_d = more ? chan_q : prev_q;
    rc_d = result_valid ? prev_q : rc_q;
    rd_d = result_valid ? data : rd_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mask_q <= '0;
      uni_q <= 1'b0;
      first_q <= 1'b0;
      chan_q <= '0;
      prev_q <= '0;
      rc_q <= '0;
      rd_q <= '0;
    end else begin
      busy_q <= busy_d;
      mask_q <= mask_d;
      uni_q <= uni_d;
      first_q <= first_d;
      chan_q <= chan_d;
      prev_q <= prev_d;
      rc_q <= rc_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed self-checking bench for adc_scan_ctrl with a converter model
module tb_adc_scan_ctrl;
  logic clk = 0, rst_n = 0, start = 0, uni = 0, adc_sdo = 0;
  logic [7:0] chan_mask = 0;
  logic adc_convst, adc_sclk, adc_sdi, busy, result_valid;
  logic [2:0] result_chan;
  logic [11:0] result_data;
`ifdef ADC_CONT_EN
  logic cont = 0;
`endif
  int total = 0, bad = 0;
  logic [11:0] words [16];
  int fi = 0, wbase = 0;
  logic [11:0] sdo_sh;
  logic [5:0] cfgs [64];
  logic [5:0] cur;
  int rise = 0, nf = 0, sdi_hi = 0;
  logic [2:0] pc [64];
  logic [11:0] pd [64];
  int np = 0;

  always #5 clk = ~clk;

  adc_scan_ctrl #(.CLK_DIV(2), .CONV_CYCLES(80)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan_mask(chan_mask), .uni(uni),
`ifdef ADC_CONT_EN
    .cont(cont),
`endif
    .adc_sdo(adc_sdo), .adc_convst(adc_convst), .adc_sclk(adc_sclk), .adc_sdi(adc_sdi),
    .busy(busy), .result_valid(result_valid), .result_chan(result_chan), .result_data(result_data)
  );

  // converter: new word per CONVST, MSB presented first, next bit on each SCLK fall
  always @(posedge adc_convst or negedge adc_sclk) begin
    if (adc_convst) begin
      sdo_sh = words[(fi - wbase) % 16];
      fi++;
    end else sdo_sh = sdo_sh << 1;
    adc_sdo = sdo_sh[11];
  end

  always @(posedge adc_convst or posedge adc_sclk) begin
    if (adc_convst) begin
      rise = 0;
      cur = '0;
    end else begin
      if (rise < 6) cur = {cur[4:0], adc_sdi};
      else if (adc_sdi) sdi_hi++;
      rise++;
      if (rise == 12) begin
        cfgs[nf % 64] = cur;
        nf++;
      end
    end
  end

  always @(negedge clk) if (result_valid) begin
    pc[np % 64] = result_chan;
    pd[np % 64] = result_data;
    np++;
  end

  task automatic load(input logic [11:0] w0, w1, w2, w3, w4);
    wbase = fi;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3; words[4] = w4;
  endtask

  task automatic kick(input logic [7:0] m, input logic u);
    @(negedge clk);
    chan_mask = m; uni = u; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input int lim, output bit to);
    to = 1;
    for (int i = 0; i < lim; i++) begin
      if (!busy) begin to = 0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (adc_convst !== 1'b0) begin bad++; $display("FAIL rst_convst: got %b want 0", adc_convst); end
    total++; if (adc_sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", adc_sclk); end
    total++; if (adc_sdi !== 1'b0) begin bad++; $display("FAIL rst_sdi: got %b want 0", adc_sdi); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", result_valid); end
    total++; if ({result_chan, result_data} !== 15'h0) begin bad++; $display("FAIL rst_result: got %h/%h want 0/000", result_chan, result_data); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single(input string tag);
    int n0, p0;
    bit to;
    n0 = nf; p0 = np;
    load(12'hC6F, 12'h49E, 12'h0, 12'h0, 12'h0);
    kick(8'h01, 1'b1);
    wait_idle(1000, to);
    repeat (3) @(negedge clk);
    total++; if (to) begin bad++; $display("FAIL %s_timeout: busy=%b want 0", tag, busy); end
    total++; if (nf - n0 != 2) begin bad++; $display("FAIL %s_frames: got %0d want 2", tag, nf - n0); end
    for (int i = 0; i < 2; i++) begin
      total++; if (cfgs[(n0 + i) % 64] !== 6'b100010) begin bad++; $display("FAIL %s_cfg%0d: got %b want 100010", tag, i, cfgs[(n0 + i) % 64]); end
    end
    total++; if (np - p0 != 1) begin bad++; $display("FAIL %s_pulses: got %0d want 1", tag, np - p0); end
    total++; if (pc[p0 % 64] !== 3'd0 || pd[p0 % 64] !== 12'h49E) begin bad++; $display("FAIL %s_result: got %0d/%h want 0/49e", tag, pc[p0 % 64], pd[p0 % 64]); end
    total++; if (result_chan !== 3'd0 || result_data !== 12'h49E) begin bad++; $display("FAIL %s_hold: got %0d/%h want 0/49e", tag, result_chan, result_data); end
  endtask

  task automatic test_timing;
    int hi, cyc, rises, first, lastr;
    bit ps, to;
    hi = 0; cyc = 0; rises = 0; first = -1; lastr = -1; ps = 0;
    load(12'h5A5, 12'hA5A, 12'h0, 12'h0, 12'h0);
    kick(8'h01, 1'b0);
    for (int i = 0; i < 300 && adc_convst; i++) begin hi++; @(negedge clk); end
    for (int i = 0; i < 300 && !adc_convst; i++) begin
      if (adc_sclk && !ps) begin
        rises++;
        if (first < 0) first = cyc;
        lastr = cyc;
      end
      ps = adc_sclk;
      cyc++;
      @(negedge clk);
    end
    total++; if (hi != 80) begin bad++; $display("FAIL convst_width: got %0d want 80", hi); end
    total++; if (cyc != 49) begin bad++; $display("FAIL shift_gap_len: got %0d want 49", cyc); end
    total++; if (rises != 12) begin bad++; $display("FAIL sclk_rises: got %0d want 12", rises); end
    total++; if (first != 2 || lastr != 46) begin bad++; $display("FAIL sclk_phase: got %0d..%0d want 2..46", first, lastr); end
    wait_idle(500, to);
    total++; if (to) begin bad++; $display("FAIL timing_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_multi;
    int n0, p0, s0;
    bit to;
    logic [5:0] ec [4];
    logic [2:0] ech [3];
    logic [11:0] edat [3];
    ec = '{6'b100110, 6'b111010, 6'b111110, 6'b100110};
    ech = '{3'd2, 3'd5, 3'd7};
    edat = '{12'h222, 12'h333, 12'h444};
    n0 = nf; p0 = np; s0 = sdi_hi;
    load(12'h111, 12'h222, 12'h333, 12'h444, 12'h0);
    kick(8'hA4, 1'b1);
    wait_idle(1000, to);
    repeat (2) @(negedge clk);
    total++; if (to) begin bad++; $display("FAIL multi_timeout: busy=%b want 0", busy); end
    total++; if (nf - n0 != 4) begin bad++; $display("FAIL multi_frames: got %0d want 4", nf - n0); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cfgs[(n0 + i) % 64] !== ec[i]) begin bad++; $display("FAIL multi_cfg%0d: got %b want %b", i, cfgs[(n0 + i) % 64], ec[i]); end
    end
    total++; if (sdi_hi != s0) begin bad++; $display("FAIL multi_sdi_tail: got %0d high bits want 0", sdi_hi - s0); end
    total++; if (np - p0 != 3) begin bad++; $display("FAIL multi_pulses: got %0d want 3", np - p0); end
    for (int i = 0; i < 3; i++) begin
      total++; if (pc[(p0 + i) % 64] !== ech[i] || pd[(p0 + i) % 64] !== edat[i]) begin bad++; $display("FAIL multi_res%0d: got %0d/%h want %0d/%h", i, pc[(p0 + i) % 64], pd[(p0 + i) % 64], ech[i], edat[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int n0, p0;
    bit to, seen;
    seen = 0;
    kick(8'h00, 1'b1);
    repeat (5) begin if (busy || adc_convst) seen = 1; @(negedge clk); end
    total++; if (seen) begin bad++; $display("FAIL zero_mask: busy/convst=1 want 0"); end
    n0 = nf; p0 = np;
    load(12'hAAA, 12'h123, 12'h456, 12'h0, 12'h0);
    kick(8'h03, 1'b0);
    repeat (200) @(negedge clk);
    kick(8'hFF, 1'b1);
    wait_idle(1000, to);
    repeat (2) @(negedge clk);
    total++; if (to) begin bad++; $display("FAIL busy_start_timeout: busy=%b want 0", busy); end
    total++; if (nf - n0 != 3) begin bad++; $display("FAIL busy_start_frames: got %0d want 3", nf - n0); end
    total++; if (cfgs[n0 % 64] !== 6'b100000 || cfgs[(n0 + 1) % 64] !== 6'b110000 || cfgs[(n0 + 2) % 64] !== 6'b100000) begin bad++; $display("FAIL busy_start_cfg: got %b %b %b want 100000 110000 100000", cfgs[n0 % 64], cfgs[(n0 + 1) % 64], cfgs[(n0 + 2) % 64]); end
    total++; if (np - p0 != 2 || pc[p0 % 64] !== 3'd0 || pd[p0 % 64] !== 12'h123 || pc[(p0 + 1) % 64] !== 3'd1 || pd[(p0 + 1) % 64] !== 12'h456) begin bad++; $display("FAIL busy_start_res: got n=%0d %0d/%h %0d/%h want 2 0/123 1/456", np - p0, pc[p0 % 64], pd[p0 % 64], pc[(p0 + 1) % 64], pd[(p0 + 1) % 64]); end
    load(12'h0, 12'h321, 12'h0, 12'h0, 12'h0);
    kick(8'h01, 1'b1);
    to = 1;
    for (int i = 0; i < 400; i++) begin
      if (result_valid) begin to = 0; break; end
      @(negedge clk);
    end
    chan_mask = 8'h01; start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    repeat (5) begin if (busy) seen = 1; @(negedge clk); end
    total++; if (to || seen) begin bad++; $display("FAIL last_gap_start: timeout=%b busy_seen=%b want 0/0", to, seen); end
  endtask

  task automatic test_reset_mid;
    int rises, p0;
    bit ps, seen;
    rises = 0; ps = 0; seen = 0;
    load(12'h777, 12'h888, 12'h0, 12'h0, 12'h0);
    kick(8'h01, 1'b1);
    for (int i = 0; i < 1000 && rises < 18; i++) begin
      if (adc_sclk && !ps) rises++;
      ps = adc_sclk;
      if (rises < 18) @(negedge clk);
    end
    rst_n = 0;
    @(negedge clk);
    total++; if (rises != 18) begin bad++; $display("FAIL rmid_reach: got %0d rises want 18", rises); end
    total++; if ({adc_convst, adc_sclk, adc_sdi, busy, result_valid, result_chan, result_data} !== 20'h0) begin bad++; $display("FAIL rmid_outputs: got %b%b%b%b%b %0d/%h want all 0", adc_convst, adc_sclk, adc_sdi, busy, result_valid, result_chan, result_data); end
    rst_n = 1;
    p0 = np;
    repeat (300) begin if (busy || adc_convst) seen = 1; @(negedge clk); end
    total++; if (np != p0 || seen) begin bad++; $display("FAIL rmid_quiet: got %0d pulses busy_seen=%b want 0/0", np - p0, seen); end
    test_single("after_rst");
  endtask

`ifdef ADC_CONT_EN
  task automatic test_cont;
    int n0, p0;
    bit to, drop;
    logic [2:0] ech [4];
    logic [11:0] edat [4];
    ech = '{3'd0, 3'd1, 3'd0, 3'd1};
    edat = '{12'h102, 12'h103, 12'h104, 12'h105};
    drop = 0; n0 = nf; p0 = np;
    load(12'h101, 12'h102, 12'h103, 12'h104, 12'h105);
    cont = 1;
    kick(8'h03, 1'b0);
    for (int i = 0; i < 1000 && np - p0 < 3; i++) begin
      if (!busy) drop = 1;
      @(negedge clk);
    end
    cont = 0;
    wait_idle(1000, to);
    repeat (2) @(negedge clk);
    total++; if (to || drop) begin bad++; $display("FAIL cont_busy: timeout=%b dropped=%b want 0/0", to, drop); end
    total++; if (nf - n0 != 5) begin bad++; $display("FAIL cont_frames: got %0d want 5", nf - n0); end
    total++; if (np - p0 != 4) begin bad++; $display("FAIL cont_pulses: got %0d want 4", np - p0); end
    for (int i = 0; i < 4; i++) begin
      total++; if (pc[(p0 + i) % 64] !== ech[i] || pd[(p0 + i) % 64] !== edat[i]) begin bad++; $display("FAIL cont_res%0d: got %0d/%h want %0d/%h", i, pc[(p0 + i) % 64], pd[(p0 + i) % 64], ech[i], edat[i]); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single("single");
    test_timing;
    test_multi;
    test_back_to_back;
    test_reset_mid;
`ifdef ADC_CONT_EN
    test_cont;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter CONV_CYCLES, default 80: clk cycles CONVST is held high per frame (1.6 us at 50 MHz).
REQ-003 Port clk  in  1  system clock; all logic on rising edge.
REQ-004 Port rst_n  in  1  synchronous, active-low reset.
REQ-005 Port start  in  1  one-cycle request to begin a scan.
REQ-006 Port chan_mask  in  8  enabled single-ended channels; bit c = CH c.
REQ-007 Port uni  in  1  1 = unipolar, 0 = bipolar; copied into config UNI bit.
REQ-008 Port adc_convst  out  1  converter CONVST.
REQ-009 Port adc_sclk  out  1  serial clock, idle low.
REQ-010 Port adc_sdi  out  1  config bits, MSB first.
REQ-011 Port adc_sdo  in  1  conversion data, MSB first; converter updates it on SCLK falling edge.
REQ-012 Port busy  out  1  high from accepted start to end of final frame.
REQ-013 Ports result_valid out 1, result_chan out 3, result_data out 12: one-cycle result strobe, channel, and code.

Function
REQ-014 The 6-bit config word SHALL be {S/D=1, O/S=c[0], S1=c[2], S0=c[1], UNI=uni, SLP=0} for channel c.
REQ-015 start SHALL be accepted only in IDLE with chan_mask != 0; chan_mask and uni are latched on acceptance. Otherwise start is ignored.
REQ-016 FSM states: IDLE, CONV, SHIFT, GAP.
- IDLE->CONV on accepted start.
- CONV->SHIFT after CONV_CYCLES.
- SHIFT->GAP after 12 bits.
- GAP->CONV if frames remain, else ->IDLE.
REQ-017 CONV: adc_convst=1 for exactly CONV_CYCLES cycles; adc_sclk=0.
REQ-018 SHIFT: each bit is CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high.
- adc_sdi changes only at the start of a low phase: config bits 5..0 for bits 0..5, then 0 for bits 6..11.
REQ-019 adc_sdo SHALL be sampled in the cycle sclk rises, MSB first, into a 12-bit shift register.
REQ-020 GAP lasts exactly 1 cycle; adc_convst=0, adc_sclk=0.
REQ-021 Frame sequencing: with n enabled channels the scan runs n+1 frames, channels visited in ascending order.
- Frame k config = k-th enabled channel (0 <= k < n).
- Frame n config = first enabled channel (flush).
REQ-022 Data shifted in frame k belongs to the config of frame k-1. Frame 0 data SHALL be discarded.
REQ-023 For k >= 1, result_valid SHALL pulse in the GAP cycle of frame k, with result_chan = channel of frame k-1 and result_data = shifted code. Exactly n pulses per scan.
REQ-024 result_chan and result_data SHALL hold their values until the next pulse.
REQ-025 busy SHALL deassert on the GAP->IDLE transition; start in that same cycle is ignored.

Reset
REQ-026 rst_n=0 SHALL force IDLE on the next edge, including mid-frame: adc_convst=0, adc_sclk=0, adc_sdi=0, busy=0, result_valid=0, result_chan=0, result_data=0, counters and latched mask cleared.
REQ-027 A scan interrupted by reset SHALL produce no further results.

Configuration
REQ-028 ADC_CONT_EN defined: adds input port cont (1 bit, meaning continuous scan).
- If cont=1 at the last GAP, the controller re-enters CONV with the latched mask and skips the discard frame, since the flush frame already primed the first channel.
- busy stays high throughout.
- Deasserting cont ends the scan after the current frame sequence completes.
REQ-029 ADC_CONT_EN undefined: no cont port; every scan is single-shot per REQ-021.

Structure
REQ-030 Package adc_pkg SHALL hold the state enum, CFG_W=6, DATA_W=12, and a function that maps channel + uni to a config word.
REQ-031 Sub-module adc_serial_if SHALL implement one frame (CONV/SHIFT/GAP timing, sdi shift, sdo capture) under a frame_go/frame_done handshake. adc_scan_ctrl owns channel sequencing.

Verification
REQ-032 chan_mask=8'h01, converter model returns 12'hC6F, 12'h49E -> frames carry config 6'b100010 twice; one pulse: chan 0, data 12'h49E.
REQ-033 chan_mask=8'hA4, uni=1 -> configs for CH2, CH5, CH7, CH2. Pulses in order for chans 2, 5, 7; sdi bits match REQ-014 (CH5 = 6'b111010).
REQ-034 CLK_DIV=2, CONV_CYCLES=80 -> frame = 80+48+1 = 129 cycles; SCLK period 4 cycles; 12 rising edges per frame.
REQ-035 start with chan_mask=0, and start asserted while busy -> both ignored; busy stays 0 in the first case, and the scan is unaltered in the second.
REQ-036 rst_n low during SHIFT bit 5 -> all outputs at reset values next cycle; no result_valid afterwards. A new start then behaves as REQ-032.
REQ-037 ADC_CONT_EN, cont=1, chan_mask=8'h03 -> pulses repeat chan 0, 1, 0, 1 with no discard frame between scans. cont=0 -> stop after the next chan 1 pulse.
